// File: rtl/cci_responder_pkg.sv
// Shared CCI field layout, response-type codes and the stamp arithmetic
// used by the responder and its request FIFOs.
package cci_responder_pkg;

    localparam int CLADDR_MSB   = 45;
    localparam int CLADDR_LSB   = 14;
    localparam int CLADDR_W     = 32;
    localparam int MDATA_MSB    = 13;
    localparam int MDATA_LSB    = 0;
    localparam int MDATA_W      = 14;
    localparam int RESPTYPE_MSB = 17;
    localparam int RESPTYPE_LSB = 14;
    localparam int STAMP_W      = 16;

    localparam logic [3:0] RESP_RD = 4'h4;
    localparam logic [3:0] RESP_WR = 4'h1;

    typedef struct packed {
        logic [MDATA_W-1:0]  mdata;
        logic [CLADDR_W-1:0] claddr;
        logic [STAMP_W-1:0]  stamp;
    } rd_entry_t;

    typedef struct packed {
        logic [MDATA_W-1:0] mdata;
        logic [STAMP_W-1:0] stamp;
    } wr_entry_t;

    // Modular age keeps the latency exact across the stamp wrap.
    function automatic logic latency_met(input logic [STAMP_W-1:0] now,
                                         input logic [STAMP_W-1:0] stamp,
                                         input logic [STAMP_W-1:0] lat);
        logic [STAMP_W-1:0] age;
        age = now - stamp;
        return (age >= lat);
    endfunction

endpackage

// File: rtl/cci_resp_fifo.sv
// Synchronous FIFO with combinational head view; pushes on full are ignored.
module cci_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against current occupancy.
    always_comb begin
        do_push_s = push && (count_r != DEPTH_C);
        do_pop_s  = pop && (count_r != {(AW+1){1'b0}});
        head      = mem_r[rd_ptr_r];
        count     = count_r;
        full      = (count_r == DEPTH_C);
        empty     = (count_r == {(AW+1){1'b0}});
    end

    // Entry storage, not reset: occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cci_responder.sv
// Platform-side CCI responder: line memory behind read/write request FIFOs,
// responses released after fixed stamp-measured latencies.
module cci_responder #(
    parameter int TX_HDR_WIDTH = 61,
    parameter int RX_HDR_WIDTH = 18,
    parameter int DATA_WIDTH   = 512,
    parameter int MEM_LINES    = 1024,
    parameter int FIFO_DEPTH   = 32,
    parameter int AF_THRESH    = 4,
    parameter int RD_LATENCY   = 8,
    parameter int WR_LATENCY   = 4,
    parameter int INIT_CYCLES  = 16
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic [TX_HDR_WIDTH-1:0] tx_c0_header,
    input  logic                    tx_c0_rdvalid,
    input  logic [TX_HDR_WIDTH-1:0] tx_c1_header,
    input  logic [DATA_WIDTH-1:0]   tx_c1_data,
    input  logic                    tx_c1_wrvalid,
    output logic                    tx_c0_almostfull,
    output logic                    tx_c1_almostfull,
    output logic [RX_HDR_WIDTH-1:0] rx_c0_header,
    output logic [DATA_WIDTH-1:0]   rx_c0_data,
    output logic                    rx_c0_rdvalid,
    output logic [RX_HDR_WIDTH-1:0] rx_c1_header,
    output logic                    rx_c1_wrvalid,
    output logic                    lp_initdone,
    output logic                    err_overflow,
    output logic                    err_early
);
    import cci_responder_pkg::*;

    localparam int IDX_W  = $clog2(MEM_LINES);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam logic [STAMP_W-1:0] RD_LAT_C    = STAMP_W'(RD_LATENCY);
    localparam logic [STAMP_W-1:0] WR_LAT_C    = STAMP_W'(WR_LATENCY);
    localparam logic [CNT_W-1:0]   AF_LVL_C    = CNT_W'(FIFO_DEPTH - AF_THRESH);
    localparam logic [INIT_W-1:0]  INIT_LAST_C = INIT_W'(INIT_CYCLES - 1);

    logic [DATA_WIDTH-1:0] mem_r [MEM_LINES];
    logic [MEM_LINES-1:0]  line_valid_r;
    logic [STAMP_W-1:0]    stamp_r;
    logic [INIT_W-1:0]     init_cnt_r;

    rd_entry_t             rd_push_s, rd_head_s;
    wr_entry_t             wr_push_s, wr_head_s;
    logic [CNT_W-1:0]      rd_count_s, wr_count_s;
    logic                  rd_full_s, rd_empty_s, wr_full_s, wr_empty_s;
    logic                  rd_acc_s, wr_acc_s, rd_pop_s, wr_pop_s;
    logic [IDX_W-1:0]      rd_idx_s, wr_idx_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    // Acceptance, release and read-data selection.
    always_comb begin
        rd_acc_s         = tx_c0_rdvalid && lp_initdone && !rd_full_s;
        wr_acc_s         = tx_c1_wrvalid && lp_initdone && !wr_full_s;
        rd_push_s.mdata  = tx_c0_header[MDATA_MSB:MDATA_LSB];
        rd_push_s.claddr = tx_c0_header[CLADDR_MSB:CLADDR_LSB];
        rd_push_s.stamp  = stamp_r;
        wr_push_s.mdata  = tx_c1_header[MDATA_MSB:MDATA_LSB];
        wr_push_s.stamp  = stamp_r;
        rd_pop_s         = !rd_empty_s && latency_met(stamp_r, rd_head_s.stamp, RD_LAT_C);
        wr_pop_s         = !wr_empty_s && latency_met(stamp_r, wr_head_s.stamp, WR_LAT_C);
        rd_idx_s         = rd_head_s.claddr[IDX_W-1:0];
        wr_idx_s         = tx_c1_header[CLADDR_LSB+IDX_W-1:CLADDR_LSB];
        // A write landing on the same edge is forwarded so the read sees it.
        if (wr_acc_s && (wr_idx_s == rd_idx_s)) begin
            rd_data_s = tx_c1_data;
        end else if (line_valid_r[rd_idx_s]) begin
            rd_data_s = mem_r[rd_idx_s];
        end else begin
            rd_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    cci_resp_fifo #(.WIDTH($bits(rd_entry_t)), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk       (clk),
        .resetb    (resetb),
        .push      (rd_acc_s),
        .push_data (rd_push_s),
        .pop       (rd_pop_s),
        .head      (rd_head_s),
        .count     (rd_count_s),
        .full      (rd_full_s),
        .empty     (rd_empty_s)
    );

    cci_resp_fifo #(.WIDTH($bits(wr_entry_t)), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk       (clk),
        .resetb    (resetb),
        .push      (wr_acc_s),
        .push_data (wr_push_s),
        .pop       (wr_pop_s),
        .head      (wr_head_s),
        .count     (wr_count_s),
        .full      (wr_full_s),
        .empty     (wr_empty_s)
    );

    // Line storage, written at the accepting edge.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_idx_s] <= tx_c1_data;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            line_valid_r     <= {MEM_LINES{1'b0}};
            stamp_r          <= {STAMP_W{1'b0}};
            init_cnt_r       <= {INIT_W{1'b0}};
            lp_initdone      <= 1'b0;
            tx_c0_almostfull <= 1'b0;
            tx_c1_almostfull <= 1'b0;
            rx_c0_header     <= {RX_HDR_WIDTH{1'b0}};
            rx_c0_data       <= {DATA_WIDTH{1'b0}};
            rx_c0_rdvalid    <= 1'b0;
            rx_c1_header     <= {RX_HDR_WIDTH{1'b0}};
            rx_c1_wrvalid    <= 1'b0;
            err_overflow     <= 1'b0;
            err_early        <= 1'b0;
        end else begin
            stamp_r <= stamp_r + {{(STAMP_W-1){1'b0}}, 1'b1};
            if (!lp_initdone) begin
                if (init_cnt_r == INIT_LAST_C) lp_initdone <= 1'b1;
                else                           init_cnt_r  <= init_cnt_r + {{(INIT_W-1){1'b0}}, 1'b1};
            end
            if (wr_acc_s) line_valid_r[wr_idx_s] <= 1'b1;
            tx_c0_almostfull <= (rd_count_s >= AF_LVL_C);
            tx_c1_almostfull <= (wr_count_s >= AF_LVL_C);
            rx_c0_rdvalid    <= rd_pop_s;
            rx_c1_wrvalid    <= wr_pop_s;
            if (rd_pop_s) begin
                rx_c0_header                            <= {RX_HDR_WIDTH{1'b0}};
                rx_c0_header[RESPTYPE_MSB:RESPTYPE_LSB] <= RESP_RD;
                rx_c0_header[MDATA_MSB:MDATA_LSB]       <= rd_head_s.mdata;
                rx_c0_data                              <= rd_data_s;
            end
            if (wr_pop_s) begin
                rx_c1_header                            <= {RX_HDR_WIDTH{1'b0}};
                rx_c1_header[RESPTYPE_MSB:RESPTYPE_LSB] <= RESP_WR;
                rx_c1_header[MDATA_MSB:MDATA_LSB]       <= wr_head_s.mdata;
            end
            err_early    <= err_early | ((tx_c0_rdvalid | tx_c1_wrvalid) & ~lp_initdone);
            err_overflow <= err_overflow | (lp_initdone & ((tx_c0_rdvalid & rd_full_s) |
                                                           (tx_c1_wrvalid & wr_full_s)));
        end
    end

endmodule

// File: tb/tb_cci_responder.sv
// Scoreboard bench for cci_responder: directed requests queue expected
// responses, a negedge monitor matches header, data and arrival cycle.
`timescale 1ns/1ps
module tb_cci_responder;
    localparam int TXW = 61, RXW = 18, DW = 512, LINES = 1024, DEPTH = 32;
    localparam int AFT = 4, RDL = 48, WRL = 4, INITC = 16;

    logic           clk = 1'b0;
    logic           resetb = 1'b0;
    logic [TXW-1:0] tx_c0_header = '0, tx_c1_header = '0;
    logic [DW-1:0]  tx_c1_data = '0;
    logic           tx_c0_rdvalid = 1'b0, tx_c1_wrvalid = 1'b0;
    logic           tx_c0_almostfull, tx_c1_almostfull, rx_c0_rdvalid, rx_c1_wrvalid;
    logic [RXW-1:0] rx_c0_header, rx_c1_header;
    logic [DW-1:0]  rx_c0_data;
    logic           lp_initdone, err_overflow, err_early;

    cci_responder #(.TX_HDR_WIDTH(TXW), .RX_HDR_WIDTH(RXW), .DATA_WIDTH(DW),
        .MEM_LINES(LINES), .FIFO_DEPTH(DEPTH), .AF_THRESH(AFT), .RD_LATENCY(RDL),
        .WR_LATENCY(WRL), .INIT_CYCLES(INITC)) dut (
        .clk(clk), .resetb(resetb),
        .tx_c0_header(tx_c0_header), .tx_c0_rdvalid(tx_c0_rdvalid),
        .tx_c1_header(tx_c1_header), .tx_c1_data(tx_c1_data), .tx_c1_wrvalid(tx_c1_wrvalid),
        .tx_c0_almostfull(tx_c0_almostfull), .tx_c1_almostfull(tx_c1_almostfull),
        .rx_c0_header(rx_c0_header), .rx_c0_data(rx_c0_data), .rx_c0_rdvalid(rx_c0_rdvalid),
        .rx_c1_header(rx_c1_header), .rx_c1_wrvalid(rx_c1_wrvalid),
        .lp_initdone(lp_initdone), .err_overflow(err_overflow), .err_early(err_early));

    always #5 clk = ~clk;

    typedef struct {
        logic [RXW-1:0] hdr;
        logic [DW-1:0]  data;
        int             exp_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    logic [DW-1:0] mem_model [int];
    int checks = 0;
    int errors = 0;
    int gcyc = 0;
    int rel_cyc = 0;

    always @(posedge clk) gcyc <= gcyc + 1;
    always @(posedge clk or negedge resetb)
        if (!resetb) rel_cyc <= 0;
        else         rel_cyc <= rel_cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_data(input logic [31:0] a);
        int idx;
        idx = int'(a % LINES);
        if (mem_model.exists(idx)) return mem_model[idx];
        else                       return '0;
    endfunction

    task automatic drive_rd(input logic [31:0] a, input logic [13:0] m, input bit expect_resp);
        exp_t e;
        tx_c0_header        = '0;
        tx_c0_header[45:14] = a;
        tx_c0_header[13:0]  = m;
        tx_c0_rdvalid       = 1'b1;
        if (expect_resp) begin
            e.hdr     = {4'h4, m};
            e.data    = model_data(a);
            e.exp_cyc = gcyc + 1 + RDL;
            q0.push_back(e);
        end
    endtask

    task automatic drive_wr(input logic [31:0] a, input logic [13:0] m, input logic [DW-1:0] d);
        exp_t e;
        tx_c1_header        = '0;
        tx_c1_header[45:14] = a;
        tx_c1_header[13:0]  = m;
        tx_c1_data          = d;
        tx_c1_wrvalid       = 1'b1;
        mem_model[int'(a % LINES)] = d;
        e.hdr     = {4'h1, m};
        e.data    = '0;
        e.exp_cyc = gcyc + 1 + WRL;
        q1.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tx_c0_rdvalid = 1'b0;
        tx_c1_wrvalid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_initdone"}, lp_initdone, 1'b0);
        check({tag, "_rdvalid"}, rx_c0_rdvalid, 1'b0);
        check({tag, "_wrvalid"}, rx_c1_wrvalid, 1'b0);
        check({tag, "_rdhdr"}, rx_c0_header, '0);
        check({tag, "_wrhdr"}, rx_c1_header, '0);
        check({tag, "_rddata"}, rx_c0_data, '0);
        check({tag, "_af"}, {tx_c0_almostfull, tx_c1_almostfull}, 2'b00);
        check({tag, "_errs"}, {err_overflow, err_early}, 2'b00);
    endtask

    // Response monitor: pops expectations as responses appear.
    always @(negedge clk) begin
        if (rx_c0_rdvalid) begin
            if (q0.size() == 0) check("rd_unexpected_valid", rx_c0_rdvalid, 1'b0);
            else begin
                e0 = q0.pop_front();
                check("rd_hdr", rx_c0_header, e0.hdr);
                check("rd_data", rx_c0_data, e0.data);
                check("rd_cycle", gcyc, e0.exp_cyc);
            end
        end else if (q0.size() != 0 && gcyc >= q0[0].exp_cyc) begin
            e0 = q0.pop_front();
            check("rd_timeout_valid", rx_c0_rdvalid, 1'b1);
        end
        if (rx_c1_wrvalid) begin
            if (q1.size() == 0) check("wr_unexpected_valid", rx_c1_wrvalid, 1'b0);
            else begin
                e1 = q1.pop_front();
                check("wr_hdr", rx_c1_header, e1.hdr);
                check("wr_cycle", gcyc, e1.exp_cyc);
            end
        end else if (q1.size() != 0 && gcyc >= q1[0].exp_cyc) begin
            e1 = q1.pop_front();
            check("wr_timeout_valid", rx_c1_wrvalid, 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) resetb = 1'b1;

        // Init: request sampled at edge 5 is dropped as early.
        repeat (4) step();
        drive_rd(32'h5, 14'h1, 1'b0);
        step();
        idle();
        check("early_flag", err_early, 1'b1);
        check("early_no_ovf", err_overflow, 1'b0);
        repeat (10) step();
        check("initdone_edge15", lp_initdone, 1'b0);
        step();
        check("initdone_edge16", lp_initdone, 1'b1);

        // Same-cycle write and read to line 0x40.
        drive_wr(32'h40, 14'h11, {64{8'hA5}});
        drive_rd(32'h40, 14'h22, 1'b1);
        step();
        idle();
        drive_rd(32'h7, 14'h33, 1'b1);
        drive_wr(32'h41, 14'h12, {16{32'hDEADBEEF}});
        step();
        idle();
        step();
        drive_rd(32'h441, 14'h34, 1'b1);
        step();
        idle();
        repeat (RDL + 5) step();

        // Overflow: 40 back-to-back reads ignoring almost-full.
        check("af_before", tx_c0_almostfull, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            drive_rd(32'h100 + i, 14'(i), i <= 32);
            step();
            if (i == 28) check("af_after28", tx_c0_almostfull, 1'b0);
            if (i == 29) check("af_after29", tx_c0_almostfull, 1'b1);
        end
        idle();
        check("overflow_flag", err_overflow, 1'b1);
        repeat (RDL + 40) step();
        check("overflow_drained", q0.size(), 0);

        // Stamp wrap: reads issued around stamp 65534.
        while (rel_cyc < 65534) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive_rd(32'h40, 14'(12'h200 + i), 1'b1);
            step();
        end
        idle();
        repeat (RDL + 5) step();

        // Reset with 10 reads outstanding.
        for (int i = 0; i < 10; i++) begin
            drive_rd(32'h40, 14'(12'h300 + i), 1'b1);
            step();
        end
        idle();
        repeat (5) step();
        resetb = 1'b0;
        q0.delete();
        q1.delete();
        mem_model.delete();
        #1;
        check_all_zero("midreset");
        repeat (3) step();
        check("midreset_hold_rdvalid", rx_c0_rdvalid, 1'b0);
        @(negedge clk) resetb = 1'b1;
        repeat (15) step();
        check("reinit_edge15", lp_initdone, 1'b0);
        step();
        check("reinit_edge16", lp_initdone, 1'b1);
        drive_rd(32'h40, 14'h3F, 1'b1);
        step();
        idle();
        repeat (RDL + 5) step();
        check("final_drained", q0.size() + q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
